// File: rtl/mtr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtr_drv_pkg
// Description : Shared widths, constants and speed-to-duty mapping for mtr_drv.
// Revision    : 1.0 - initial release
// ============================================================================
package mtr_drv_pkg;

    localparam int PWM_W         = 11;
    localparam int PRD           = 2048;
    localparam int DEADTIME_DFLT = 32;

    typedef logic [PWM_W-1:0] duty_t;

    localparam duty_t DUTY_ZERO = 11'h400;
    localparam duty_t CNT_LAST  = duty_t'(PRD - 1);

    // Offset-binary conversion of the signed command; bit 0 carries no duty weight.
    function automatic duty_t spd2duty(input logic [11:1] spd_hi);
        return {~spd_hi[11], spd_hi[10:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm11_dt.sv
`default_nettype none
// ============================================================================
// Module      : pwm11_dt
// Description : Raw PWM comparator plus dead-time insertion for one H-bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm11_dt
    import mtr_drv_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DFLT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  duty_t cnt,
    input  duty_t duty_q,
    output logic  PWM1,
    output logic  PWM2
);

    localparam logic [7:0] c_deadtime = 8'(DEADTIME);

    logic       r_raw;
    logic       r_pwm1;
    logic       r_pwm2;
    logic [7:0] r_dcnt;
    logic       w_raw_nxt;
    logic       w_tgl;

    assign w_raw_nxt = (cnt < duty_q);
    assign w_tgl     = w_raw_nxt ^ r_raw;

    // The gate registers reload on the same edge the counter reaches zero,
    // so both legs are low for exactly DEADTIME clocks after a raw edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw  <= 1'b0;
            r_dcnt <= c_deadtime;
            r_pwm1 <= 1'b0;
            r_pwm2 <= 1'b0;
        end else begin
            r_raw <= w_raw_nxt;
            if (!en || w_tgl) begin
                r_dcnt <= c_deadtime;
                r_pwm1 <= 1'b0;
                r_pwm2 <= 1'b0;
            end else if (r_dcnt > 8'd1) begin
                r_dcnt <= r_dcnt - 8'd1;
                r_pwm1 <= 1'b0;
                r_pwm2 <= 1'b0;
            end else begin
                r_dcnt <= 8'd0;
                r_pwm1 <= w_raw_nxt;
                r_pwm2 <= ~w_raw_nxt;
            end
        end
    end

    assign PWM1 = r_pwm1;
    assign PWM2 = r_pwm2;

endmodule
`default_nettype wire

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
// Module      : mtr_drv
// Description : Dual-channel dead-time protected PWM motor drive stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    output logic               lft_PWM1,
    output logic               lft_PWM2,
    output logic               rght_PWM1,
    output logic               rght_PWM2,
    output logic               prd_strt
);

    duty_t r_cnt;
    duty_t r_duty_lft;
    duty_t r_duty_rght;
    logic  r_prd_strt;
    logic  w_prd_end;
    logic  w_unused_lsb;

    assign w_prd_end    = (r_cnt == CNT_LAST);
    assign w_unused_lsb = lft_spd[0] ^ rght_spd[0];

    // Duty only changes at the period boundary so a period never sees two duties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_duty_lft  <= DUTY_ZERO;
            r_duty_rght <= DUTY_ZERO;
            r_prd_strt  <= 1'b0;
        end else begin
            r_cnt      <= r_cnt + duty_t'(1);
            r_prd_strt <= w_prd_end;
            if (w_prd_end) begin
                r_duty_lft  <= spd2duty(lft_spd[11:1]);
                r_duty_rght <= spd2duty(rght_spd[11:1]);
            end
        end
    end

    assign prd_strt = r_prd_strt;

    pwm11_dt #(
        .DEADTIME (DEADTIME)
    ) u_pwm_lft (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cnt    (r_cnt),
        .duty_q (r_duty_lft),
        .PWM1   (lft_PWM1),
        .PWM2   (lft_PWM2)
    );

    pwm11_dt #(
        .DEADTIME (DEADTIME)
    ) u_pwm_rght (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cnt    (r_cnt),
        .duty_q (r_duty_rght),
        .PWM1   (rght_PWM1),
        .PWM2   (rght_PWM2)
    );

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtr_drv
// Description : Self-checking bench for mtr_drv at DEADTIME 32, 1 and 200.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_drv;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;

    logic d32_l1, d32_l2, d32_r1, d32_r2, d32_ps;
    logic d1_l1, d1_l2, d1_r1, d1_r2, d1_ps;
    logic d200_l1, d200_l2, d200_r1, d200_r2, d200_ps;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    mtr_drv #(.DEADTIME(32)) u_dut (
        .clk(clk), .rst(rst), .en(en), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .lft_PWM1(d32_l1), .lft_PWM2(d32_l2), .rght_PWM1(d32_r1), .rght_PWM2(d32_r2),
        .prd_strt(d32_ps)
    );

    mtr_drv #(.DEADTIME(1)) u_dut_dt1 (
        .clk(clk), .rst(rst), .en(en), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .lft_PWM1(d1_l1), .lft_PWM2(d1_l2), .rght_PWM1(d1_r1), .rght_PWM2(d1_r2),
        .prd_strt(d1_ps)
    );

    mtr_drv #(.DEADTIME(200)) u_dut_dt200 (
        .clk(clk), .rst(rst), .en(en), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .lft_PWM1(d200_l1), .lft_PWM2(d200_l2), .rght_PWM1(d200_r1), .rght_PWM2(d200_r2),
        .prd_strt(d200_ps)
    );

    // Reference: a leg may drive only once raw has been steady (and enabled)
    // for at least DEADTIME consecutive clocks.
    int m_cnt, m_duty_l, m_duty_r;
    bit m_raw_l, m_raw_r, m_ps, m_nl, m_nr;
    int m_quiet [3][2];
    int c_dts [3] = '{32, 1, 200};

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_duty_l = 1024; m_duty_r = 1024;
            m_raw_l = 1'b0; m_raw_r = 1'b0; m_ps = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_quiet[i][0] = 0; m_quiet[i][1] = 0;
            end
        end else begin
            m_nl = (m_cnt < m_duty_l);
            m_nr = (m_cnt < m_duty_r);
            for (int i = 0; i < 3; i++) begin
                m_quiet[i][0] = (!en || m_nl != m_raw_l) ? 0 : ((m_quiet[i][0] >= 1000) ? 1000 : m_quiet[i][0] + 1);
                m_quiet[i][1] = (!en || m_nr != m_raw_r) ? 0 : ((m_quiet[i][1] >= 1000) ? 1000 : m_quiet[i][1] + 1);
            end
            m_ps = (m_cnt == 2047);
            if (m_cnt == 2047) begin
                m_duty_l = (int'(lft_spd) + 2048) / 2;
                m_duty_r = (int'(rght_spd) + 2048) / 2;
            end
            m_cnt = (m_cnt + 1) % 2048;
            m_raw_l = m_nl;
            m_raw_r = m_nr;
        end
    end

    function automatic logic [14:0] exp_vec();
        logic [14:0] v;
        bit okl, okr;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            okl = (m_quiet[i][0] >= c_dts[i]);
            okr = (m_quiet[i][1] >= c_dts[i]);
            v[i*5 +: 5] = {okl & m_raw_l, okl & !m_raw_l, okr & m_raw_r, okr & !m_raw_r, m_ps};
        end
        return v;
    endfunction

    function automatic logic [14:0] dut_vec();
        return {d200_l1, d200_l2, d200_r1, d200_r2, d200_ps,
                d1_l1, d1_l2, d1_r1, d1_r2, d1_ps,
                d32_l1, d32_l2, d32_r1, d32_r2, d32_ps};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; lft_spd = '0; rght_spd = '0;
        repeat (3) @(negedge clk);
        total++; if ({d32_l1, d32_l2, d32_r1, d32_r2, d32_ps} !== 5'b0) begin bad++; $display("FAIL reset_dt32 got=%b exp=00000", {d32_l1, d32_l2, d32_r1, d32_r2, d32_ps}); end
        total++; if ({d1_l1, d1_l2, d1_r1, d1_r2, d1_ps} !== 5'b0) begin bad++; $display("FAIL reset_dt1 got=%b exp=00000", {d1_l1, d1_l2, d1_r1, d1_r2, d1_ps}); end
        total++; if ({d200_l1, d200_l2, d200_r1, d200_r2, d200_ps} !== 5'b0) begin bad++; $display("FAIL reset_dt200 got=%b exp=00000", {d200_l1, d200_l2, d200_r1, d200_r2, d200_ps}); end
        total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec()); end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_zero_speed();
        int n_l1, n_l2, n_r1, n_r2;
        n_l1 = 0; n_l2 = 0; n_r1 = 0; n_r2 = 0;
        lft_spd = '0; rght_spd = '0;
        for (int i = 0; i < 6144; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL zero_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
            if (i >= 2048) begin
                n_l1 += int'(d32_l1); n_l2 += int'(d32_l2); n_r1 += int'(d32_r1); n_r2 += int'(d32_r2);
            end
        end
        total++; if (n_l1 != 1984) begin bad++; $display("FAIL zero_lft_pwm1_hi got=%0d exp=1984", n_l1); end
        total++; if (n_l2 != 1984) begin bad++; $display("FAIL zero_lft_pwm2_hi got=%0d exp=1984", n_l2); end
        total++; if (n_r1 != 1984) begin bad++; $display("FAIL zero_rght_pwm1_hi got=%0d exp=1984", n_r1); end
        total++; if (n_r2 != 1984) begin bad++; $display("FAIL zero_rght_pwm2_hi got=%0d exp=1984", n_r2); end
    endtask

    task automatic test_full_scale();
        int n_l1, n_l2, n_r1, n_r2;
        n_l1 = 0; n_l2 = 0; n_r1 = 0; n_r2 = 0;
        lft_spd = 12'sh7FF; rght_spd = 12'sh800;
        for (int i = 0; i < 8192; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL full_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
            if (i >= 4096) begin
                n_l1 += int'(d32_l1); n_l2 += int'(d32_l2); n_r1 += int'(d32_r1); n_r2 += int'(d32_r2);
            end
        end
        total++; if (n_l1 != 4030) begin bad++; $display("FAIL full_lft_pwm1_hi got=%0d exp=4030", n_l1); end
        total++; if (n_l2 != 0)    begin bad++; $display("FAIL full_lft_pwm2_hi got=%0d exp=0", n_l2); end
        total++; if (n_r1 != 0)    begin bad++; $display("FAIL full_rght_pwm1_hi got=%0d exp=0", n_r1); end
        total++; if (n_r2 != 4096) begin bad++; $display("FAIL full_rght_pwm2_hi got=%0d exp=4096", n_r2); end
    endtask

    task automatic test_mid_update();
        bit found;
        int h, hr;
        lft_spd = '0; rght_spd = '0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL mid_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
        end
        found = 1'b0;
        for (int i = 0; i < 2100 && !found; i++) begin
            @(negedge clk);
            if (d32_ps === 1'b1) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL mid_sync got=no_prd_strt exp=prd_strt"); end
        h = 0; hr = 0;
        for (int i = 1; i < 2048; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL mid_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
            h += int'(d32_l1); hr += int'(d32_r1);
            if (i == 100) begin lft_spd = 12'sh400; rght_spd = 12'sh400; end
        end
        total++; if (h != 992) begin bad++; $display("FAIL mid_cur_period_hi got=%0d exp=992", h); end
        total++; if (hr != 992) begin bad++; $display("FAIL mid_cur_period_hi_r got=%0d exp=992", hr); end
        h = 0; hr = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL mid_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
            if (i == 0) begin
                total++; if (d32_ps !== 1'b1) begin bad++; $display("FAIL mid_prd_strt got=%b exp=1", d32_ps); end
            end
            h += int'(d32_l1); hr += int'(d32_r1);
        end
        total++; if (h != 1504) begin bad++; $display("FAIL mid_next_period_hi got=%0d exp=1504", h); end
        total++; if (hr != 1504) begin bad++; $display("FAIL mid_next_period_hi_r got=%0d exp=1504", hr); end
    endtask

    task automatic test_enable();
        bit found;
        logic prev;
        lft_spd = '0; rght_spd = '0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL en_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
        end
        found = 1'b0; prev = d32_l1;
        for (int i = 0; i < 4200 && !found; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && d32_l1 === 1'b1) found = 1'b1;
            prev = d32_l1;
        end
        total++; if (!found) begin bad++; $display("FAIL en_find_pwm1 got=no_rise exp=rise"); end
        en = 1'b0;
        @(negedge clk);
        total++; if ({d32_l1, d32_l2, d32_r1, d32_r2, d1_l1, d1_l2, d1_r1, d1_r2, d200_l1, d200_l2, d200_r1, d200_r2} !== 12'h000) begin
            bad++; $display("FAIL en_drop got=%b exp=0", {d32_l1, d32_l2, d32_r1, d32_r2, d1_l1, d1_l2, d1_r1, d1_r2, d200_l1, d200_l2, d200_r1, d200_r2});
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL en_low_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
        end
        en = 1'b1;
        for (int j = 0; j < 31; j++) begin
            @(negedge clk);
            total++; if ({d32_l1, d32_l2, d32_r1, d32_r2} !== 4'b0) begin bad++; $display("FAIL en_rise_hold j=%0d got=%b exp=0000", j, {d32_l1, d32_l2, d32_r1, d32_r2}); end
        end
        @(negedge clk);
        total++; if ({d32_l1, d32_l2} !== 2'b10) begin bad++; $display("FAIL en_rise_follow got=%b exp=10", {d32_l1, d32_l2}); end
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL en_after_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic prev;
        int h, ps_at;
        found = 1'b0; prev = d32_l2;
        for (int i = 0; i < 4200 && !found; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && d32_l2 === 1'b1) found = 1'b1;
            prev = d32_l2;
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_find_pwm2 got=no_rise exp=rise"); end
        lft_spd = 12'($urandom); rght_spd = 12'($urandom);
        rst = 1'b1;
        @(negedge clk);
        total++; if (dut_vec() !== 15'h0) begin bad++; $display("FAIL rstmid_outputs got=%h exp=0000", dut_vec()); end
        rst = 1'b0;
        h = 0; ps_at = 0;
        for (int k = 1; k <= 2048; k++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
            h += int'(d32_l1);
            if (d32_ps === 1'b1 && ps_at == 0) ps_at = k;
        end
        total++; if (ps_at != 2048) begin bad++; $display("FAIL rstmid_first_prd_strt got=%0d exp=2048", ps_at); end
        total++; if (h != 992) begin bad++; $display("FAIL rstmid_duty_zero_hi got=%0d exp=992", h); end
    endtask

    task automatic test_random_sweep();
        int last_ps, nps;
        last_ps = -1; nps = 0;
        for (int c = 0; c < 12 * 2048; c++) begin
            @(negedge clk);
            total++; if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rand_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec()); end
            total++; if (((d32_l1 & d32_l2) | (d32_r1 & d32_r2) | (d1_l1 & d1_l2) | (d1_r1 & d1_r2) | (d200_l1 & d200_l2) | (d200_r1 & d200_r2)) !== 1'b0) begin
                bad++; $display("FAIL rand_shoot_through t=%0t got=1 exp=0", $time);
            end
            if (d32_ps === 1'b1) begin
                if (last_ps >= 0) begin
                    total++; if (c - last_ps != 2048) begin bad++; $display("FAIL rand_prd_interval got=%0d exp=2048", c - last_ps); end
                end
                last_ps = c; nps++;
            end
            if ($urandom_range(0, 399) == 0) begin
                case ($urandom_range(0, 3))
                    0:       lft_spd = 12'sh800;
                    1:       lft_spd = 12'sh7FF;
                    default: lft_spd = 12'($urandom);
                endcase
                rght_spd = 12'($urandom);
            end
            if ($urandom_range(0, 2999) == 0) en = ~en;
        end
        en = 1'b1;
        total++; if (nps < 11) begin bad++; $display("FAIL rand_prd_count got=%0d exp=>=11", nps); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; lft_spd = '0; rght_spd = '0;
        test_reset();
        test_zero_speed();
        test_full_scale();
        test_mid_update();
        test_enable();
        test_reset_mid();
        test_random_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
